ram_port_arbiter: RTL and testbench

Single-clock controller that shares one port of the dual-port RAM (`dp_ram_init`, port A) between two requesters and adds a built-in clear sequencer. It sits directly in front of the RAM port. It does round-robin arbitration of valid/ready requests and returns read data one cycle after acceptance. On command, it takes the port exclusively and writes a fill value to every address.

---
 rtl/ram_port_arbiter_if.sv | 38 +++
 rtl/ram_port_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bundle between the RAM port arbiter and its two requesters, the clear
// control, and RAM port A of dp_ram_init.
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 10
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_we;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [DATA_WIDTH-1:0] req_wdata0;
    logic [DATA_WIDTH-1:0] req_wdata1;
    logic [1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  clear_start;
    logic [DATA_WIDTH-1:0] clear_value;
    logic                  clear_busy;
    logic                  clear_done;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  clear_start, clear_value, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, clear_busy, clear_done,
        output ram_wr_en, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output clear_start, clear_value, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, clear_busy, clear_done,
        input  ram_wr_en, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for two requesters on one RAM port, with a clear
// sequencer that takes the port exclusively and fills every address.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_port_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    // One extra counter bit keeps the terminal compare from aliasing with 0.
    localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] ONE_CNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_r, state_s;
    logic [ADDR_WIDTH:0]   cnt_r, cnt_s;
    logic [DATA_WIDTH-1:0] fill_r, fill_s;
    logic                  last_r, last_s;
    logic [1:0]            grant_s;
    logic [1:0]            rsp_valid_r, rsp_valid_s;
    logic                  busy_r;
    logic                  done_r, done_s;
    logic                  ram_wr_en_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_din_s;

    // Arbitration, RAM port drive and clear sequencing for the current cycle.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        fill_s      = fill_r;
        last_s      = last_r;
        grant_s     = 2'b00;
        done_s      = 1'b0;
        rsp_valid_s = 2'b00;
        ram_wr_en_s = 1'b0;
        ram_addr_s  = {ADDR_WIDTH{1'b0}};
        ram_din_s   = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                // last_r set means requester 1 was served last, so 0 wins a tie.
                if (bus.req_valid == 2'b11) begin
                    grant_s = last_r ? 2'b01 : 2'b10;
                end else if (bus.req_valid[0]) begin
                    grant_s = 2'b01;
                end else if (bus.req_valid[1]) begin
                    grant_s = 2'b10;
                end else begin
                    grant_s = 2'b00;
                end
                if (grant_s[0]) begin
                    ram_wr_en_s = bus.req_we[0];
                    ram_addr_s  = bus.req_addr0;
                    ram_din_s   = bus.req_wdata0;
                    last_s      = 1'b0;
                end else if (grant_s[1]) begin
                    ram_wr_en_s = bus.req_we[1];
                    ram_addr_s  = bus.req_addr1;
                    ram_din_s   = bus.req_wdata1;
                    last_s      = 1'b1;
                end else begin
                    last_s      = last_r;
                end
                rsp_valid_s = grant_s & ~bus.req_we;
                if (bus.clear_start) begin
                    state_s = ST_CLEAR;
                    cnt_s   = {(ADDR_WIDTH+1){1'b0}};
                    fill_s  = bus.clear_value;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                ram_wr_en_s = 1'b1;
                ram_addr_s  = cnt_r[ADDR_WIDTH-1:0];
                ram_din_s   = fill_r;
                if (cnt_r == LAST_CNT) begin
                    state_s = ST_IDLE;
                    cnt_s   = {(ADDR_WIDTH+1){1'b0}};
                    done_s  = 1'b1;
                end else begin
                    cnt_s   = cnt_r + ONE_CNT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {(ADDR_WIDTH+1){1'b0}};
            end
        endcase
    end

    // State, counter, pointer and registered status/response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {(ADDR_WIDTH+1){1'b0}};
            fill_r      <= {DATA_WIDTH{1'b0}};
            last_r      <= 1'b1;
            rsp_valid_r <= 2'b00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            fill_r      <= fill_s;
            last_r      <= last_s;
            rsp_valid_r <= rsp_valid_s;
            busy_r      <= (state_s == ST_CLEAR);
            done_r      <= done_s;
        end
    end

    assign bus.req_ready  = grant_s;
    assign bus.ram_wr_en  = ram_wr_en_s;
    assign bus.ram_addr   = ram_addr_s;
    assign bus.ram_din    = ram_din_s;
    assign bus.rsp_valid  = rsp_valid_r;
    // RAM output is only meaningful the cycle after an accepted read.
    assign bus.rsp_rdata  = (rsp_valid_r != 2'b00) ? bus.ram_dout : {DATA_WIDTH{1'b0}};
    assign bus.clear_busy = busy_r;
    assign bus.clear_done = done_r;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with a behavioural registered-read RAM and a
// read-response scoreboard fed from a shadow copy of the memory contents.
module tb_ram_port_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;

    typedef struct {
        logic [1:0]    vld;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic ram_init;
    logic [DW-1:0] mem [0:15];
    logic [DW-1:0] ram_dout_r;
    logic [DW-1:0] shadow [0:15];
    exp_t exp_q [$];
    int total;
    int bad;
    int fill_seq;
    int fill_cnt;
    logic [DW-1:0] fill_val;
    logic exp_last;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM port A: synchronous write, registered read-before-write.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i) ^ 8'h50;
            ram_dout_r <= 8'h00;
        end else begin
            if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_din;
            ram_dout_r <= mem[bus.ram_addr];
        end
    end
    assign bus.ram_dout = ram_dout_r;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ram_init = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_rdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_rsp: ready=%b rsp_valid=%b rdata=%h want 00/00/00", bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
        end
        total++;
        if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_clear: busy=%b done=%b want 0/0", bus.clear_busy, bus.clear_done);
        end
        total++;
        if (bus.ram_wr_en !== 1'b0 || bus.ram_addr !== 4'h0 || bus.ram_din !== 8'h00) begin
            bad++;
            $display("FAIL reset_ram: wr_en=%b addr=%h din=%h want 0/0/00", bus.ram_wr_en, bus.ram_addr, bus.ram_din);
        end
        @(posedge clk);
        #1;
        ram_init = 1'b0;
        rst_n = 1'b1;
        exp_last = 1'b1;
        next_cycle();
    endtask

    task automatic test_write_read();
        bus.req_valid = 2'b01; bus.req_we = 2'b01; bus.req_addr0 = 4'd3; bus.req_wdata0 = 8'hA5;
        #1;
        total++;
        if (bus.req_ready !== 2'b01 || bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 4'd3 || bus.ram_din !== 8'hA5) begin
            bad++;
            $display("FAIL wr_grant: ready=%b wr_en=%b addr=%h din=%h want 01/1/3/a5", bus.req_ready, bus.ram_wr_en, bus.ram_addr, bus.ram_din);
        end
        exp_last = 1'b0;
        next_cycle();
        bus.req_we = 2'b00;
        #1;
        total++;
        if (bus.req_ready !== 2'b01 || bus.ram_wr_en !== 1'b0 || bus.ram_addr !== 4'd3) begin
            bad++;
            $display("FAIL rd_grant: ready=%b wr_en=%b addr=%h want 01/0/3", bus.req_ready, bus.ram_wr_en, bus.ram_addr);
        end
        next_cycle();
        bus.req_valid = 2'b00;
        #1;
        total++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'hA5) begin
            bad++;
            $display("FAIL rd_rsp: rsp_valid=%b rdata=%h want 01/a5", bus.rsp_valid, bus.rsp_rdata);
        end
        total++;
        if (bus.req_ready !== 2'b00 || bus.ram_wr_en !== 1'b0 || bus.ram_addr !== 4'h0 || bus.ram_din !== 8'h00) begin
            bad++;
            $display("FAIL idle_drive: ready=%b wr_en=%b addr=%h din=%h want 00/0/0/00", bus.req_ready, bus.ram_wr_en, bus.ram_addr, bus.ram_din);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [1:0] want;
        logic [1:0] prev;
        bus.req_valid = 2'b10; bus.req_we = 2'b10; bus.req_addr1 = 4'd2; bus.req_wdata1 = 8'h2B;
        #1;
        total++;
        if (bus.req_ready !== 2'b10 || bus.ram_din !== 8'h2B) begin
            bad++;
            $display("FAIL wr1_grant: ready=%b din=%h want 10/2b", bus.req_ready, bus.ram_din);
        end
        exp_last = 1'b1;
        next_cycle();
        bus.req_valid = 2'b11; bus.req_we = 2'b00; bus.req_addr0 = 4'd1; bus.req_addr1 = 4'd2;
        prev = 2'b00;
        for (int i = 0; i < 6; i++) begin
            #1;
            want = exp_last ? 2'b01 : 2'b10;
            total++;
            if (bus.req_ready !== want) begin
                bad++;
                $display("FAIL b2b_grant%0d: ready=%b want %b", i, bus.req_ready, want);
            end
            if (i > 0) begin
                total++;
                if (bus.rsp_valid !== prev) begin
                    bad++;
                    $display("FAIL b2b_rsp%0d: rsp_valid=%b want %b", i, bus.rsp_valid, prev);
                end
            end
            prev = want;
            exp_last = want[1];
            next_cycle();
        end
        bus.req_valid = 2'b00;
        next_cycle();
    endtask

    task automatic test_clear();
        logic [1:0] want;
        logic [3:0] raddr [3];
        raddr[0] = 4'd0; raddr[1] = 4'd7; raddr[2] = 4'd15;
        bus.clear_start = 1'b1; bus.clear_value = 8'h3C;
        #1;
        total++;
        if (bus.clear_busy !== 1'b0) begin
            bad++;
            $display("FAIL clr_start_busy: busy=%b want 0", bus.clear_busy);
        end
        next_cycle();
        bus.clear_start = 1'b0; bus.clear_value = 8'hFF;
        bus.req_valid = 2'b11; bus.req_we = 2'b00; bus.req_addr0 = 4'd1; bus.req_addr1 = 4'd2;
        for (int i = 0; i < 16; i++) begin
            #1;
            total++;
            if (bus.clear_busy !== 1'b1 || bus.clear_done !== 1'b0 || bus.req_ready !== 2'b00) begin
                bad++;
                $display("FAIL clr_ctl%0d: busy=%b done=%b ready=%b want 1/0/00", i, bus.clear_busy, bus.clear_done, bus.req_ready);
            end
            total++;
            if (bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 4'(i) || bus.ram_din !== 8'h3C) begin
                bad++;
                $display("FAIL clr_wr%0d: wr_en=%b addr=%h din=%h want 1/%h/3c", i, bus.ram_wr_en, bus.ram_addr, bus.ram_din, 4'(i));
            end
            next_cycle();
        end
        fill_val = 8'h3C; fill_cnt = 16; fill_seq++;
        #1;
        want = exp_last ? 2'b01 : 2'b10;
        total++;
        if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b1) begin
            bad++;
            $display("FAIL clr_done: busy=%b done=%b want 0/1", bus.clear_busy, bus.clear_done);
        end
        total++;
        if (bus.req_ready !== want) begin
            bad++;
            $display("FAIL clr_first_grant: ready=%b want %b", bus.req_ready, want);
        end
        exp_last = want[1];
        next_cycle();
        bus.req_valid = 2'b00;
        #1;
        total++;
        if (bus.clear_done !== 1'b0 || bus.clear_busy !== 1'b0) begin
            bad++;
            $display("FAIL clr_done_pulse: done=%b busy=%b want 0/0", bus.clear_done, bus.clear_busy);
        end
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 2'b01; bus.req_addr0 = raddr[k];
            #1;
            total++;
            if (bus.req_ready !== 2'b01) begin
                bad++;
                $display("FAIL clr_readback%0d: ready=%b want 01", k, bus.req_ready);
            end
            exp_last = 1'b0;
            next_cycle();
        end
        bus.req_valid = 2'b00;
        next_cycle();
    endtask

    task automatic test_clear_read();
        bit seen;
        bus.req_valid = 2'b01; bus.req_we = 2'b01; bus.req_addr0 = 4'd9; bus.req_wdata0 = 8'h77;
        next_cycle();
        bus.req_we = 2'b00; bus.clear_start = 1'b1; bus.clear_value = 8'h11;
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin
            bad++;
            $display("FAIL clrrd_grant: ready=%b want 01", bus.req_ready);
        end
        exp_last = 1'b0;
        next_cycle();
        bus.req_valid = 2'b00; bus.clear_start = 1'b0;
        #1;
        total++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'h77 || bus.clear_busy !== 1'b1 || bus.ram_addr !== 4'd0) begin
            bad++;
            $display("FAIL clrrd_rsp: rsp_valid=%b rdata=%h busy=%b addr=%h want 01/77/1/0", bus.rsp_valid, bus.rsp_rdata, bus.clear_busy, bus.ram_addr);
        end
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            next_cycle();
            #1;
            if (bus.clear_done === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL clrrd_done_timeout: done never seen, want a pulse within 40 cycles");
        end
        fill_val = 8'h11; fill_cnt = 16; fill_seq++;
        next_cycle();
    endtask

    task automatic test_reset_mid_clear();
        bus.clear_start = 1'b1; bus.clear_value = 8'h5A;
        next_cycle();
        bus.clear_start = 1'b0;
        for (int i = 0; i < 5; i++) next_cycle();
        #1;
        total++;
        if (bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 4'd5) begin
            bad++;
            $display("FAIL rst_at_wr5: wr_en=%b addr=%h want 1/5", bus.ram_wr_en, bus.ram_addr);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.ram_wr_en !== 1'b0 ||
            bus.ram_addr !== 4'h0 || bus.ram_din !== 8'h00 || bus.req_ready !== 2'b00 ||
            bus.rsp_valid !== 2'b00 || bus.rsp_rdata !== 8'h00) begin
            bad++;
            $display("FAIL rst_async: busy=%b done=%b wr_en=%b addr=%h din=%h ready=%b rsp=%b rdata=%h want all 0",
                     bus.clear_busy, bus.clear_done, bus.ram_wr_en, bus.ram_addr, bus.ram_din,
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
        end
        next_cycle();
        rst_n = 1'b1;
        exp_last = 1'b1;
        fill_val = 8'h5A; fill_cnt = 5; fill_seq++;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            total++;
            if (bus.clear_done !== 1'b0 || bus.clear_busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_no_done%0d: done=%b busy=%b want 0/0", k, bus.clear_done, bus.clear_busy);
            end
        end
        bus.req_valid = 2'b11; bus.req_we = 2'b00; bus.req_addr0 = 4'd6; bus.req_addr1 = 4'd4;
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin
            bad++;
            $display("FAIL rst_tie: ready=%b want 01", bus.req_ready);
        end
        exp_last = 1'b0;
        next_cycle();
        bus.req_valid = 2'b01;
        for (int a = 7; a < 16; a++) begin
            bus.req_addr0 = 4'(a);
            #1;
            total++;
            if (bus.req_ready !== 2'b01) begin
                bad++;
                $display("FAIL rst_read%0d: ready=%b want 01", a, bus.req_ready);
            end
            next_cycle();
        end
        bus.req_valid = 2'b10; bus.req_addr1 = 4'd4;
        #1;
        total++;
        if (bus.req_ready !== 2'b10) begin
            bad++;
            $display("FAIL rst_read1: ready=%b want 10", bus.req_ready);
        end
        next_cycle();
        bus.req_addr1 = 4'd5;
        next_cycle();
        bus.req_valid = 2'b00;
        repeat (2) next_cycle();
    endtask

    initial begin
        total = 0; bad = 0;
        fill_seq = 0; fill_cnt = 0; fill_val = 8'h00;
        exp_last = 1'b1;
        rst_n = 1'b0; ram_init = 1'b1;
        bus.req_valid = 2'b00; bus.req_we = 2'b00;
        bus.req_addr0 = 4'h0; bus.req_addr1 = 4'h0;
        bus.req_wdata0 = 8'h00; bus.req_wdata1 = 8'h00;
        bus.clear_start = 1'b0; bus.clear_value = 8'h00;
        for (int i = 0; i < 16; i++) shadow[i] = 8'(i) ^ 8'h50;

        // Scoreboard: expected reads pushed at acceptance, popped the next cycle.
        fork
            begin
                int fill_seen;
                exp_t e;
                fill_seen = 0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        exp_q.delete();
                        total++;
                        if (bus.rsp_valid !== 2'b00 || bus.rsp_rdata !== 8'h00) begin
                            bad++;
                            $display("FAIL sb_reset_rsp: rsp_valid=%b rdata=%h want 00/00", bus.rsp_valid, bus.rsp_rdata);
                        end
                    end else begin
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            total++;
                            if (bus.rsp_valid !== e.vld || bus.rsp_rdata !== e.data) begin
                                bad++;
                                $display("FAIL sb_rsp: rsp_valid=%b rdata=%h want %b/%h", bus.rsp_valid, bus.rsp_rdata, e.vld, e.data);
                            end
                        end else begin
                            total++;
                            if (bus.rsp_valid !== 2'b00 || bus.rsp_rdata !== 8'h00) begin
                                bad++;
                                $display("FAIL sb_idle_rsp: rsp_valid=%b rdata=%h want 00/00", bus.rsp_valid, bus.rsp_rdata);
                            end
                        end
                        if (fill_seq != fill_seen) begin
                            for (int i = 0; i < fill_cnt; i++) shadow[i] = fill_val;
                            fill_seen = fill_seq;
                        end
                        for (int r = 0; r < 2; r++) begin
                            if (bus.req_valid[r] && bus.req_ready[r]) begin
                                if (bus.req_we[r]) begin
                                    if (r == 0) shadow[bus.req_addr0] = bus.req_wdata0;
                                    else        shadow[bus.req_addr1] = bus.req_wdata1;
                                end else begin
                                    e.vld  = (r == 0) ? 2'b01 : 2'b10;
                                    e.data = (r == 0) ? shadow[bus.req_addr0] : shadow[bus.req_addr1];
                                    exp_q.push_back(e);
                                end
                            end
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_write_read();
        test_back_to_back();
        test_clear();
        test_clear_read();
        test_reset_mid_clear();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
